// File: rtl/hilo_md_ctrl_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide sequencer.
package hilo_md_ctrl_pkg;

  localparam int unsigned MD_WIDTH     = 32;
  localparam logic [1:0]  RHL_SEL_BOTH = 2'b10;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_md_ctrl_if.sv
// EX-stage request and HI/LO result bundle for the multiply/divide sequencer.
interface hilo_md_ctrl_if
  import hilo_md_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) ();

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             stall_req;
  logic             busy;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall_req, busy, hilo_we, hi_out, lo_out
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall_req, busy, hilo_we, hi_out, lo_out
  );

endinterface

// File: rtl/md_iter_datapath.sv
// Shift-add multiply / restoring divide datapath with sign correction and result registers.
module md_iter_datapath
  import hilo_md_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  md_op_t           i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  logic [ACC_W-1:0] r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_upper;
  logic [WIDTH:0]   w_addend;
  logic             w_cin;
  logic [WIDTH+1:0] w_sum;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_new;
  logic [ACC_W-1:0] w_acc_step;
  logic [ACC_W-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  // Operand magnitudes; the most negative value maps onto itself, which is correct unsigned.
  always_comb begin
    w_sa    = md_is_signed(i_op) & i_src_a[WIDTH-1];
    w_sb    = md_is_signed(i_op) & i_src_b[WIDTH-1];
    w_mag_a = w_sa ? -i_src_a : i_src_a;
    w_mag_b = w_sb ? -i_src_b : i_src_b;
  end

  // One shared adder: multiplicand add for multiply, trial subtract of the divisor for divide.
  always_comb begin
    if (r_is_div) begin
      w_upper  = r_acc[ACC_W-1:WIDTH-1];
      w_addend = ~{1'b0, r_opnd};
      w_cin    = 1'b1;
    end else begin
      w_upper  = {1'b0, r_acc[ACC_W-1:WIDTH]};
      w_addend = r_acc[0] ? {1'b0, r_opnd} : '0;
      w_cin    = 1'b0;
    end
    w_sum       = {1'b0, w_upper} + {1'b0, w_addend} + (WIDTH+2)'(w_cin);
    w_no_borrow = w_sum[WIDTH+1];
    w_rem_new   = w_no_borrow ? w_sum[WIDTH-1:0] : w_upper[WIDTH-1:0];
    if (r_is_div) begin
      w_acc_step = {w_rem_new, r_acc[WIDTH-2:0], w_no_borrow};
    end else begin
      w_acc_step = {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
    end
  end

  // Quotient follows the sign xor, remainder follows the dividend, product negates as a whole.
  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    if (r_is_div) begin
      w_lo_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_hi_fix = r_neg_r ? -r_acc[ACC_W-1:WIDTH] : r_acc[ACC_W-1:WIDTH];
    end else begin
      w_lo_fix = w_prod_fix[WIDTH-1:0];
      w_hi_fix = w_prod_fix[ACC_W-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (i_load) begin
        r_is_div <= md_is_div(i_op);
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_acc    <= md_is_div(i_op) ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
        r_opnd   <= md_is_div(i_op) ? w_mag_b : w_mag_a;
      end else if (i_step) begin
        r_acc <= w_acc_step;
      end
      if (i_fix) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, pipeline stall and flush handling.
module hilo_md_ctrl
  import hilo_md_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input logic           clk,
  input logic           rst,
  hilo_md_ctrl_if.slave bus
);

  localparam int unsigned     CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_stall_req;
  logic             w_busy;
  logic             w_hilo_we;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_accept = bus.start & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Flush wins in every state; start is ignored in DONE since the instruction is still in EX.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start) w_state_nxt = CALC;
        CALC:    if (r_cnt == LAST_ITER) w_state_nxt = FIX;
        FIX:     w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    w_stall_req = 1'b0;
    w_hilo_we   = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        w_load      = w_accept;
        w_stall_req = w_accept;
      end
      CALC: begin
        w_step      = ~bus.flush;
        w_stall_req = ~bus.flush;
      end
      FIX: begin
        w_fix       = ~bus.flush;
        w_stall_req = ~bus.flush;
      end
      DONE:    w_hilo_we = ~bus.flush;
      default: ;
    endcase
  end

  md_iter_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_fix   (w_fix),
    .i_op    (bus.op),
    .i_src_a (bus.src_a),
    .i_src_b (bus.src_b),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  assign bus.stall_req = w_stall_req;
  assign bus.busy      = w_busy;
  assign bus.hilo_we   = w_hilo_we;
  assign bus.hi_out    = w_hi;
  assign bus.lo_out    = w_lo;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl: cycle-exact stall/write timing and hand-computed HI/LO results.
module tb_hilo_md_ctrl;
  import hilo_md_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  vec_t vecs [10] = '{
    '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
    '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1},
    '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
    '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF},
    '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001},
    '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E},
    '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
    '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780}
  };

  hilo_md_ctrl_if bus ();

  hilo_md_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = s;
    bus.op    = md_op_t'(op);
    bus.src_a = a;
    bus.src_b = b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.stall_req, bus.busy, bus.hilo_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: stall/busy/we=%b want 000", {bus.stall_req, bus.busy, bus.hilo_we});
    end
    n_cmp++;
    if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", bus.hi_out, bus.lo_out);
    end
    next_cycle();
    last_hi = 32'h0;
    last_lo = 32'h0;
  endtask

  task automatic test_arith;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      for (int c = 0; c <= 34; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({bus.stall_req, bus.busy, bus.hilo_we} !== {c < 34, c > 0, c == 34}) begin
          n_fail++;
          $display("FAIL arith%0d_cyc%0d: stall/busy/we=%b want %b", i, c,
                   {bus.stall_req, bus.busy, bus.hilo_we}, {c < 34, c > 0, c == 34});
        end
        if (c == 34) begin
          n_cmp++;
          if ({bus.hi_out, bus.lo_out} !== {vecs[i].hi, vecs[i].lo}) begin
            n_fail++;
            $display("FAIL arith%0d_result: hi=%h lo=%h want hi=%h lo=%h", i,
                     bus.hi_out, bus.lo_out, vecs[i].hi, vecs[i].lo);
          end
        end
        next_cycle();
      end
      bus.start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.hilo_we !== 1'b0 ||
          {bus.hi_out, bus.lo_out} !== {vecs[i].hi, vecs[i].lo}) begin
        n_fail++;
        $display("FAIL arith%0d_hold: busy=%b we=%b hi=%h lo=%h want 0 0 %h %h", i,
                 bus.busy, bus.hilo_we, bus.hi_out, bus.lo_out, vecs[i].hi, vecs[i].lo);
      end
      next_cycle();
      last_hi = vecs[i].hi;
      last_lo = vecs[i].lo;
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 2'b11, 32'd100, 32'd7);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.stall_req, bus.hilo_we} !== 2'b10) begin
        n_fail++;
        $display("FAIL flush_pre_cyc%0d: stall/we=%b want 10", c, {bus.stall_req, bus.hilo_we});
      end
      next_cycle();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.stall_req, bus.hilo_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_cycle: stall/we=%b want 00", {bus.stall_req, bus.hilo_we});
    end
    next_cycle();
    bus.flush = 1'b0;
    drive(1'b1, 2'b01, 32'h0001_0000, 32'h0001_0000);
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.stall_req, bus.hilo_we} !== {c < 34, c == 34}) begin
        n_fail++;
        $display("FAIL flush_restart_cyc%0d: stall/we=%b want %b", c + 11,
                 {bus.stall_req, bus.hilo_we}, {c < 34, c == 34});
      end
      n_cmp++;
      if (c < 34 && {bus.hi_out, bus.lo_out} !== {last_hi, last_lo}) begin
        n_fail++;
        $display("FAIL flush_hilo_kept_cyc%0d: hi=%h lo=%h want %h %h", c + 11,
                 bus.hi_out, bus.lo_out, last_hi, last_lo);
      end else if (c == 34 && {bus.hi_out, bus.lo_out} !== {32'h1, 32'h0}) begin
        n_fail++;
        $display("FAIL flush_restart_result: hi=%h lo=%h want 00000001 00000000",
                 bus.hi_out, bus.lo_out);
      end
      next_cycle();
    end
    bus.start = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'b11, 32'd100, 32'd7);
    for (int c = 0; c <= 69; c++) begin
      if (c == 35) drive(1'b1, 2'b00, 32'd7, 32'hFFFF_FFFE);
      @(negedge clk);
      n_cmp++;
      if ({bus.stall_req, bus.hilo_we} !== {!(c == 34 || c == 69), (c == 34 || c == 69)}) begin
        n_fail++;
        $display("FAIL b2b_cyc%0d: stall/we=%b want %b", c, {bus.stall_req, bus.hilo_we},
                 {!(c == 34 || c == 69), (c == 34 || c == 69)});
      end
      if (c == 34) begin
        n_cmp++;
        if ({bus.hi_out, bus.lo_out} !== {32'h2, 32'hE}) begin
          n_fail++;
          $display("FAIL b2b_first: hi=%h lo=%h want 00000002 0000000e", bus.hi_out, bus.lo_out);
        end
      end
      if (c == 69) begin
        n_cmp++;
        if ({bus.hi_out, bus.lo_out} !== {32'hFFFF_FFFF, 32'hFFFF_FFF2}) begin
          n_fail++;
          $display("FAIL b2b_second: hi=%h lo=%h want ffffffff fffffff2", bus.hi_out, bus.lo_out);
        end
      end
      next_cycle();
    end
    bus.start = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush_done;
    drive(1'b1, 2'b01, 32'd3, 32'd4);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.stall_req !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_done_pre_cyc%0d: stall=%b want 1", c, bus.stall_req);
      end
      next_cycle();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.stall_req, bus.hilo_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_done_we: stall/we=%b want 00", {bus.stall_req, bus.hilo_we});
    end
    next_cycle();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.hilo_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_done_after%0d: busy/we=%b want 00", c, {bus.busy, bus.hilo_we});
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_fix;
    drive(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5);
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.stall_req !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_fix_pre_cyc%0d: stall=%b want 1", c, bus.stall_req);
      end
      next_cycle();
    end
    rst = 1'b1;
    bus.start = 1'b0;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.stall_req, bus.busy, bus.hilo_we} !== 3'b000 || {bus.hi_out, bus.lo_out} !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_fix_after%0d: stall/busy/we=%b hi=%h lo=%h want 000 0 0", c,
                 {bus.stall_req, bus.busy, bus.hilo_we}, bus.hi_out, bus.lo_out);
      end
      next_cycle();
    end
  endtask

  initial begin
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_arith();
    test_flush();
    test_back_to_back();
    test_flush_done();
    test_reset_fix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Sequencer for the iterative multiply/divide unit that owns the HI/LO write port. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a one-bit-per-cycle shift-add multiply or restoring divide. It holds the pipeline through the existing stall path while busy, then issues a single combined HI+LO write. The unit sits beside the ALU in EX. Its write feeds the HI/LO register and the HI/LO bypass as a "both" write (RHLSelWr = 2'b10).

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a multiply/divide instruction; level, held while stalled.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs operand after bypass (multiplicand / dividend).
- src_b  in  WIDTH  rt operand after bypass (multiplier / divisor).
- flush  in  1  EX_MEM exception or eret flush; aborts the operation.
- stall_req  out  1  to stall logic; freezes PC, IF/ID and ID/EX.
- busy  out  1  state != IDLE.
- hilo_we  out  1  one-cycle write strobe for HI and LO together.
- hi_out  out  WIDTH  result HI (remainder / product upper half).
- lo_out  out  WIDTH  result LO (quotient / product lower half).

## Operation
- States:
  - IDLE → CALC when start && !flush. On that transition, latch the magnitudes of src_a/src_b (signed ops take the absolute value), sign flags, op, and clear the counter.
  - CALC → FIX when counter reaches WIDTH-1. CALC runs exactly WIDTH iterations.
  - FIX → DONE. FIX applies the sign correction.
  - DONE → IDLE unconditionally. start is ignored in DONE, because the same instruction is still in EX.
- Multiply: 2·WIDTH accumulator, one shift-add per CALC cycle. Signed: negate the 64-bit result if the operand signs differ.
- Divide: restoring, one quotient bit per cycle.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - DIVU by 0: lo = all-ones, hi = src_a.
  - DIV by 0: lo = all-ones when the dividend is non-negative, else 1; hi = src_a. No exception.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Both results are in 2's-complement modular arithmetic.
- stall_req = (IDLE && start && !flush) || CALC || FIX. It is combinational on start and state.
- hilo_we = DONE && !flush.
- hi_out/lo_out are registered and loaded at the FIX→DONE edge. They hold their value until the next FIX.
- flush has priority in every state: the next state is IDLE, hilo_we is suppressed that cycle, and stall_req drops the same cycle. hi_out/lo_out keep their old values.
- Reset values: state IDLE, counter 0, stall_req 0, busy 0, hilo_we 0, hi_out 0, lo_out 0.

## Timing
- Cycle 0 is when start is seen in IDLE; stall_req = 1 combinationally in that cycle.
- Cycles 1..WIDTH are CALC; cycle WIDTH+1 is FIX; cycle WIDTH+2 is DONE.
- In DONE: hilo_we = 1, stall_req = 0, and results are valid. The instruction leaves EX at the end of DONE.
- Total occupancy is WIDTH+3 cycles (35 for WIDTH=32). The next start is accepted in the cycle after DONE.
- For back-to-back ops, the next start is seen in IDLE at cycle WIDTH+3. No extra bubble beyond that.
- rst asserted mid-CALC forces IDLE on the next edge with no write.
- Overlap:
  - An MFHI/MFLO following the op is not this block's concern. It picks up the DONE write through the EX_MEM/MEM_WB HI/LO bypass.
  - This block never writes HI/LO in a cycle other than DONE.

## Structure
- Shared core package:
  - md_op_t encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - md_state_t (IDLE, CALC, FIX, DONE).
  - The RHLSelWr "both" constant 2'b10.
- One sub-module, md_iter_datapath, holds:
  - the 2·WIDTH accumulator/remainder shift register;
  - the WIDTH-bit subtractor/adder;
  - the sign-fix negation.
- md_iter_datapath is controlled by step/load/fix strobes from the FSM in hilo_md_ctrl. The FSM, counter, stall and flush logic stay in hilo_md_ctrl.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → stall_req high cycles 0..33. At cycle 34: hilo_we = 1, hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT 0xFFFFFFFD (−3) × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, one hilo_we pulse, start held throughout ignored in DONE.
- DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 0x12345678 / 0 → lo = 0xFFFFFFFF, hi = 0x12345678, no stall beyond 35 cycles.
- flush at cycle 10 of CALC → stall_req 0 that cycle, no hilo_we ever, hi/lo unchanged. A new start at cycle 11 gives a correct result at cycle 45.
- rst during FIX → IDLE next edge, all outputs 0. flush coincident with DONE → hilo_we stays 0.
